// File: rtl/risc_v_alu_seq_if.sv
// Request/response bus of the sequential execute ALU: operands and op code in,
// registered result with zero/illegal flags out, each side valid/ready handshaked.
interface risc_v_alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            illegal_op;

  modport master (
    output in_valid, op, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, result, zero_flag, illegal_op
  );

  modport slave (
    input  in_valid, op, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, result, zero_flag, illegal_op
  );
endinterface

// File: rtl/risc_v_alu_seq.sv
// Handshaked execute-stage ALU with a registered result. Define ALU_MULDIV_EN to add
// iterative multiply/divide (ops 10-17); without it those ops report illegal.
module risc_v_alu_seq #(
  parameter int          XLEN        = 32,
  parameter logic [63:0] ILLEGAL_VAL = 64'h0000_0000_DEAD_BEEF
) (
  input logic             clk,
  input logic             reset,
  risc_v_alu_seq_if.slave bus
);

  localparam int              SHW = (XLEN == 64) ? 6 : 5;
  localparam logic [XLEN-1:0] ILL = ILLEGAL_VAL[XLEN-1:0];

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;

  // Returns {illegal, result}; anything not listed falls through to the illegal value.
  function automatic logic [XLEN:0] simple_op(input logic [4:0] o,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic            ill;
    logic [SHW-1:0]  sh;
    sh  = b[SHW-1:0];
    r   = '0;
    ill = 1'b0;
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
      default: begin
        r   = ILL;
        ill = 1'b1;
      end
    endcase
    return {ill, r};
  endfunction

  logic            accept;
  logic [XLEN:0]   simple_res;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;

  assign accept         = bus.in_valid && bus.in_ready;
  assign simple_res     = simple_op(bus.op, bus.rs1_val, bus.rs2_val);
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.zero_flag  = zero_q;
  assign bus.illegal_op = illegal_q;

`ifdef ALU_MULDIV_EN

  localparam int         CW        = $clog2(XLEN);
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // One radix-2 step on {hi, lo}: shift-add for multiply, restoring subtract for divide.
  function automatic logic [2*XLEN-1:0] step(input logic mul,
                                             input logic [XLEN-1:0] h,
                                             input logic [XLEN-1:0] l,
                                             input logic [XLEN-1:0] m);
    logic [XLEN:0] t;
    logic [XLEN:0] d;
    if (mul) begin
      t = {1'b0, h} + (l[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
      return {t, l[XLEN-1:1]};
    end
    t = {h, l[XLEN-1]};
    d = t - {1'b0, m};
    if (t >= {1'b0, m}) return {d[XLEN-1:0], l[XLEN-2:0], 1'b1};
    return {t[XLEN-1:0], l[XLEN-2:0], 1'b0};
  endfunction

  state_t          state;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, mb_q, orig_q;
  logic [4:0]      mop_q;
  logic            neg_q, dz_q;

  logic            is_md, is_mul, sign_a, sign_b, start_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [2*XLEN-1:0] first_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] md_res;

  assign bus.in_ready = !reset && (state == IDLE) && (!out_valid_q || bus.out_ready);

  // Operand magnitudes and result sign are settled at acceptance; the first step runs then too.
  always_comb begin
    is_md  = (bus.op >= OP_MUL) && (bus.op <= OP_REMU);
    is_mul = bus.op <= OP_MULHU;
    sign_a = bus.rs1_val[XLEN-1] && (bus.op == OP_MUL || bus.op == OP_MULH ||
             bus.op == OP_MULHSU || bus.op == OP_DIV || bus.op == OP_REM);
    sign_b = bus.rs2_val[XLEN-1] && (bus.op == OP_MUL || bus.op == OP_MULH ||
             bus.op == OP_DIV || bus.op == OP_REM);
    mag_a  = sign_a ? -bus.rs1_val : bus.rs1_val;
    mag_b  = sign_b ? -bus.rs2_val : bus.rs2_val;
    start_neg  = (bus.op == OP_REM) ? sign_a : (sign_a ^ sign_b);
    first_step = is_mul ? step(1'b1, '0, mag_b, mag_a) : step(1'b0, '0, mag_a, mag_b);
  end

  always_comb begin
    prod   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    md_res = '0;
    case (mop_q)
      OP_MUL:                      md_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             md_res = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
      default:                     md_res = dz_q ? orig_q : (neg_q ? -hi_q : hi_q);
    endcase
  end

  // Single-cycle ops load the result directly; mul/div walk BUSY for the remaining steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mb_q        <= '0;
      orig_q      <= '0;
      mop_q       <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_md) begin
            state        <= BUSY;
            {hi_q, lo_q} <= first_step;
            mb_q         <= is_mul ? mag_a : mag_b;
            neg_q        <= start_neg;
            dz_q         <= !is_mul && (bus.rs2_val == '0);
            orig_q       <= bus.rs1_val;
            mop_q        <= bus.op;
            cnt_q        <= CW'(1);
          end else if (accept) begin
            result_q    <= simple_res[XLEN-1:0];
            illegal_q   <= simple_res[XLEN];
            zero_q      <= !simple_res[XLEN] && (simple_res[XLEN-1:0] == '0);
            out_valid_q <= 1'b1;
          end
        end
        BUSY: begin
          {hi_q, lo_q} <= step(mop_q <= OP_MULHU, hi_q, lo_q, mb_q);
          cnt_q        <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state <= DONE;
        end
        DONE: begin
          result_q    <= md_res;
          zero_q      <= (md_res == '0);
          illegal_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready);

  // Every op completes in one cycle; mul/div codes land in the illegal path.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        result_q    <= simple_res[XLEN-1:0];
        illegal_q   <= simple_res[XLEN];
        zero_q      <= !simple_res[XLEN] && (simple_res[XLEN-1:0] == '0);
        out_valid_q <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_risc_v_alu_seq.sv
// Directed bench for risc_v_alu_seq (XLEN=32); a scoreboard model checks every valid output.
module tb_risc_v_alu_seq;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  risc_v_alu_seq_if #(.XLEN(32)) bus ();

  risc_v_alu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic        zero;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t exp_q[$];

  // Expected outcome computed straight from the arithmetic rules of each op.
  function automatic exp_t model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          sa, sb;
    longint      pa, pb;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    pa = longint'(sa);
    pb = longint'(sb);
    pu = '0;
    e.res = '0; e.ill = 1'b0; e.lat = 1; e.acc = 0; e.seen = 1'b0;
    case (o)
      5'd0:  e.res = a + b;
      5'd1:  e.res = a - b;
      5'd2:  e.res = a & b;
      5'd3:  e.res = a | b;
      5'd4:  e.res = a ^ b;
      5'd5:  e.res = a << b[4:0];
      5'd6:  e.res = a >> b[4:0];
      5'd7:  e.res = sa >>> b[4:0];
      5'd8:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
      5'd10: begin pu = pa * pb; e.res = pu[31:0]; end
      5'd11: begin pu = pa * pb; e.res = pu[63:32]; end
      5'd12: begin pu = pa * longint'({32'h0, b}); e.res = pu[63:32]; end
      5'd13: begin pu = {32'h0, a} * {32'h0, b}; e.res = pu[63:32]; end
      5'd14: e.res = (b == 0) ? 32'hFFFF_FFFF :
                     (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : sa / sb;
      5'd15: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: e.res = (b == 0) ? a :
                     (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : sa % sb;
      5'd17: e.res = (b == 0) ? a : a % b;
`endif
      default: begin
        e.res = 32'hDEAD_BEEF;
        e.ill = 1'b1;
      end
    endcase
`ifdef ALU_MULDIV_EN
    if (o >= 5'd10 && o <= 5'd17) e.lat = 33;
`endif
    e.zero = !e.ill && (e.res == 32'h0);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every negedge compares a valid output against the model entry in flight.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_q.delete();
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check_output("spurious_valid", {31'b0, bus.out_valid}, 32'd0);
          end else begin
            if (!exp_q[0].seen) begin
              check_output("sb_latency", cyc - exp_q[0].acc, exp_q[0].lat);
              exp_q[0].seen = 1'b1;
            end
            check_output("sb_result", bus.result, exp_q[0].res);
            check_output("sb_illegal", {31'b0, bus.illegal_op}, {31'b0, exp_q[0].ill});
            check_output("sb_zero", {31'b0, bus.zero_flag}, {31'b0, exp_q[0].zero});
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end else if (exp_q.size() != 0) begin
          if (exp_q[0].seen) begin
            check_output("sb_valid_dropped", {31'b0, bus.out_valid}, 32'd1);
            void'(exp_q.pop_front());
          end else if (cyc - exp_q[0].acc > exp_q[0].lat) begin
            check_output("sb_late", {31'b0, bus.out_valid}, 32'd1);
            void'(exp_q.pop_front());
          end else if (exp_q[0].lat > 1) begin
            check_output("sb_busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_t e;
          e = model(bus.op, bus.rs1_val, bus.rs2_val);
          e.acc = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Presents one request and returns just after the edge that accepted it.
  task automatic apply_stimulus(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int waited;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.rs1_val  = a;
    bus.rs2_val  = b;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.in_ready && waited < 100);
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, wanted 1 (op %0d)", o);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [31:0] res, input logic ill,
                               input logic zero, input int lat);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.out_valid && waited < 100);
    check_output({name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    check_output({name, "_lat"}, waited, lat);
    check_output({name, "_res"}, bus.result, res);
    check_output({name, "_ill"}, {31'b0, bus.illegal_op}, {31'b0, ill});
    check_output({name, "_zero"}, {31'b0, bus.zero_flag}, {31'b0, zero});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, wanted $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int vcount;
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 5'd0;
    bus.rs1_val   = 32'd1;
    bus.rs2_val   = 32'd1;
    bus.out_ready = 1'b1;

    repeat (2) begin
      @(negedge clk);
      check_output("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check_output("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check_output("post_rst_result", bus.result, 32'd0);
    check_output("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);

    apply_stimulus(5'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_result("add_wrap", 32'h0000_0000, 1'b0, 1'b1, 1);
    apply_stimulus(5'd7, 32'h8000_0000, 32'd4);
    expect_result("sra", 32'hF800_0000, 1'b0, 1'b0, 1);
    apply_stimulus(5'd8, 32'hFFFF_FFFF, 32'd1);
    expect_result("slt", 32'd1, 1'b0, 1'b0, 1);
    apply_stimulus(5'd9, 32'hFFFF_FFFF, 32'd1);
    expect_result("sltu", 32'd0, 1'b0, 1'b1, 1);
    apply_stimulus(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    expect_result("and", 32'h00F0_1234, 1'b0, 1'b0, 1);
    apply_stimulus(5'd3, 32'h1200_0034, 32'h0034_5600);
    expect_result("or", 32'h1234_5634, 1'b0, 1'b0, 1);
    apply_stimulus(5'd5, 32'h0000_0001, 32'h0000_003F);
    expect_result("sll_mask", 32'h8000_0000, 1'b0, 1'b0, 1);
    apply_stimulus(5'd6, 32'h8000_0000, 32'h0000_0021);
    expect_result("srl_mask", 32'h4000_0000, 1'b0, 1'b0, 1);

    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    apply_stimulus(5'd1, 32'd5, 32'd3);
    bus.in_valid = 1'b1;
    bus.op       = 5'd4;
    bus.rs1_val  = 32'h0000_F0F0;
    bus.rs2_val  = 32'h0000_FF00;
    repeat (3) begin
      @(negedge clk);
      check_output("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check_output("hold_result", bus.result, 32'd2);
      check_output("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_output("drain_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("b2b_valid", {31'b0, bus.out_valid}, 32'd1);
    check_output("b2b_result", bus.result, 32'h0000_0FF0);

    apply_stimulus(5'd25, 32'h1234_5678, 32'h0);
    expect_result("illegal", 32'hDEAD_BEEF, 1'b1, 1'b0, 1);

`ifdef ALU_MULDIV_EN
    apply_stimulus(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result("mulh", 32'h0000_0000, 1'b0, 1'b1, 33);
    apply_stimulus(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result("mulhu", 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    apply_stimulus(5'd10, 32'hFFFF_FFFD, 32'd7);
    expect_result("mul", 32'hFFFF_FFEB, 1'b0, 1'b0, 33);
    apply_stimulus(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result("mulhsu", 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    apply_stimulus(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_result("div_ovf", 32'h8000_0000, 1'b0, 1'b0, 33);
    apply_stimulus(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_result("rem_ovf", 32'h0000_0000, 1'b0, 1'b1, 33);
    apply_stimulus(5'd15, 32'd7, 32'd0);
    expect_result("divu_zero", 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    apply_stimulus(5'd14, 32'hFFFF_FFF9, 32'd0);
    expect_result("div_zero", 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    apply_stimulus(5'd17, 32'd7, 32'd0);
    expect_result("remu_zero", 32'd7, 1'b0, 1'b0, 33);
    apply_stimulus(5'd16, 32'hFFFF_FFF9, 32'd2);
    expect_result("rem_neg", 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    apply_stimulus(5'd14, 32'd100, 32'hFFFF_FFF9);
    expect_result("div_mixed", 32'hFFFF_FFF2, 1'b0, 1'b0, 33);

    apply_stimulus(5'd14, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
`else
    apply_stimulus(5'd10, 32'd3, 32'd5);
    expect_result("mul_disabled", 32'hDEAD_BEEF, 1'b1, 1'b0, 1);
    @(posedge clk); #1;
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    check_output("abort_no_valid", vcount, 32'd0);
    apply_stimulus(5'd0, 32'd1, 32'd1);
    expect_result("add_after_rst", 32'd2, 1'b0, 1'b0, 1);

    repeat (3) @(negedge clk);
    check_output("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
